// File: rtl/contador_updown_debounced.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : contador_updown_debounced
// Description : Modulo up/down counter stepped by raw push-buttons through
//               per-button synchroniser, debouncer and rising-edge detector.
// Revision    : 1.0 - initial release
// ============================================================================
module contador_updown_debounced #(
    parameter int N               = 4,
    parameter int MODULO          = 2**N,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SATURATE        = 0
) (
    input  logic         clk,
    input  logic         reset_sw,
    input  logic         inc_btn,
    input  logic         dec_btn,
    input  logic         load_en,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] count,
    output logic         at_max,
    output logic         at_min,
    output logic         wrap_pulse
);

    localparam int          c_CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [N-1:0]    c_MAX      = N'(MODULO - 1);

    logic [1:0] w_raw;
    logic [1:0] w_step;

    assign w_raw = {dec_btn, inc_btn};

    // Bit 0 handles the increment button, bit 1 the decrement button.
    generate
        for (genvar g = 0; g < 2; g++) begin : g_btn
            logic            r_sync1;
            logic            r_sync2;
            logic            r_deb;
            logic            r_prev;
            logic [c_CW-1:0] r_cnt;

            always_ff @(posedge clk or posedge reset_sw) begin
                if (reset_sw) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                    r_deb   <= 1'b0;
                    r_prev  <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_sync1 <= w_raw[g];
                    r_sync2 <= r_sync1;
                    r_prev  <= r_deb;
                    if (r_sync2 == r_deb) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_deb <= r_sync2;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
            end

            assign w_step[g] = r_deb & ~r_prev;
        end
    endgenerate

    logic [N-1:0] r_count;
    logic [N-1:0] w_count_nxt;
    logic         r_wrap;
    logic         w_wrap_nxt;

    // Limits are compared before any add/subtract so MODULO == 2**N cannot overflow.
    always_comb begin
        w_count_nxt = r_count;
        w_wrap_nxt  = 1'b0;
        if (load_en) begin
            w_count_nxt = (load_val > c_MAX) ? c_MAX : load_val;
        end else if (w_step[0] && !w_step[1]) begin
            if (r_count == c_MAX) begin
                if (SATURATE == 0) begin
                    w_count_nxt = '0;
                    w_wrap_nxt  = 1'b1;
                end
            end else begin
                w_count_nxt = r_count + N'(1);
            end
        end else if (w_step[1] && !w_step[0]) begin
            if (r_count == '0) begin
                if (SATURATE == 0) begin
                    w_count_nxt = c_MAX;
                    w_wrap_nxt  = 1'b1;
                end
            end else begin
                w_count_nxt = r_count - N'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset_sw) begin
        if (reset_sw) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

    assign count      = r_count;
    assign wrap_pulse = r_wrap;
    assign at_max     = (r_count == c_MAX);
    assign at_min     = (r_count == '0);

endmodule
`default_nettype wire

// File: tb/tb_contador_updown_debounced.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_contador_updown_debounced
// Description : Directed + random bench for a wrapping and a saturating counter
//               sharing one set of button/load inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_contador_updown_debounced;

    localparam int N   = 4;
    localparam int MOD = 10;
    localparam int D   = 4;

    logic         clk = 1'b0;
    logic         reset_sw;
    logic         inc_btn;
    logic         dec_btn;
    logic         load_en;
    logic [N-1:0] load_val;
    logic [N-1:0] count_w, count_s;
    logic         at_max_w, at_min_w, wrap_w;
    logic         at_max_s, at_min_s, wrap_s;

    int errors = 0;
    int checks = 0;
    int wrap_seen_w = 0;
    int wrap_seen_s = 0;

    // Reference state: index 0 = wrapping counter, 1 = saturating counter
    int m_cnt  [2];
    bit m_wrap [2];
    // Button state: index 0 = inc, 1 = dec
    bit m_deb  [2];
    bit m_prev [2];
    bit samp   [2][D+2];

    always #5 clk = ~clk;

    contador_updown_debounced #(.N(N), .MODULO(MOD), .DEBOUNCE_CYCLES(D), .SATURATE(0)) dut_w (
        .clk(clk), .reset_sw(reset_sw), .inc_btn(inc_btn), .dec_btn(dec_btn),
        .load_en(load_en), .load_val(load_val), .count(count_w),
        .at_max(at_max_w), .at_min(at_min_w), .wrap_pulse(wrap_w)
    );

    contador_updown_debounced #(.N(N), .MODULO(MOD), .DEBOUNCE_CYCLES(D), .SATURATE(1)) dut_s (
        .clk(clk), .reset_sw(reset_sw), .inc_btn(inc_btn), .dec_btn(dec_btn),
        .load_en(load_en), .load_val(load_val), .count(count_s),
        .at_max(at_max_s), .at_min(at_min_s), .wrap_pulse(wrap_s)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < 2; s++) begin
            m_cnt[s]  = 0;
            m_wrap[s] = 0;
            m_deb[s]  = 0;
            m_prev[s] = 0;
            for (int j = 0; j < D + 2; j++) samp[s][j] = 0;
        end
    endtask

    // A press is recognised once the button, seen two samples late, has held
    // its new level for D samples; the count moves one edge after that.
    task automatic model_edge();
        bit st_i, st_d, agree;
        bit raw [2];
        if (reset_sw) begin
            model_clear();
            return;
        end
        st_i = m_deb[0] && !m_prev[0];
        st_d = m_deb[1] && !m_prev[1];
        for (int s = 0; s < 2; s++) begin
            m_wrap[s] = 0;
            if (load_en) begin
                m_cnt[s] = (int'(load_val) > MOD - 1) ? MOD - 1 : int'(load_val);
            end else if (st_i && !st_d) begin
                if (m_cnt[s] < MOD - 1)   m_cnt[s] = m_cnt[s] + 1;
                else if (s == 0) begin m_cnt[s] = 0;       m_wrap[s] = 1; end
            end else if (st_d && !st_i) begin
                if (m_cnt[s] > 0)         m_cnt[s] = m_cnt[s] - 1;
                else if (s == 0) begin m_cnt[s] = MOD - 1; m_wrap[s] = 1; end
            end
        end
        raw[0] = inc_btn;
        raw[1] = dec_btn;
        for (int b = 0; b < 2; b++) begin
            m_prev[b] = m_deb[b];
            for (int j = D + 1; j > 0; j--) samp[b][j] = samp[b][j-1];
            samp[b][0] = raw[b];
            agree = 1;
            for (int j = 2; j < D + 2; j++) if (samp[b][j] == m_deb[b]) agree = 0;
            if (agree) m_deb[b] = !m_deb[b];
        end
    endtask

    task automatic check_all();
        chk("count_w",  8'(count_w),  8'(m_cnt[0]));
        chk("at_max_w", 8'(at_max_w), 8'(m_cnt[0] == MOD - 1));
        chk("at_min_w", 8'(at_min_w), 8'(m_cnt[0] == 0));
        chk("wrap_w",   8'(wrap_w),   8'(m_wrap[0]));
        chk("count_s",  8'(count_s),  8'(m_cnt[1]));
        chk("at_max_s", 8'(at_max_s), 8'(m_cnt[1] == MOD - 1));
        chk("at_min_s", 8'(at_min_s), 8'(m_cnt[1] == 0));
        chk("wrap_s",   8'(wrap_s),   8'(m_wrap[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        if (wrap_w === 1'b1) wrap_seen_w++;
        if (wrap_s === 1'b1) wrap_seen_s++;
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_load(input int v);
        load_val = N'(v);
        load_en  = 1'b1;
        tick();
        load_en  = 1'b0;
    endtask

    task automatic press(input bit inc, input bit dec, input int hold, input int idle);
        inc_btn = inc;
        dec_btn = dec;
        ticks(hold);
        inc_btn = 1'b0;
        dec_btn = 1'b0;
        ticks(idle);
    endtask

    task automatic do_reset();
        reset_sw = 1'b1;
        model_clear();
        ticks(3);
        reset_sw = 1'b0;
    endtask

    initial begin
        reset_sw = 1'b1;
        inc_btn  = 1'b0;
        dec_btn  = 1'b0;
        load_en  = 1'b0;
        load_val = '0;
        model_clear();
        ticks(3);
        chk("rst_count", 8'(count_w),  8'd0);
        chk("rst_at_min", 8'(at_min_w), 8'd1);
        chk("rst_at_max", 8'(at_max_w), 8'd0);
        chk("rst_wrap",   8'(wrap_w),   8'd0);
        reset_sw = 1'b0;

        // Held press: exact latency of 6 edges, then exactly one step
        inc_btn = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk("latency", 8'(count_w), (i >= 7) ? 8'd1 : 8'd0);
        end
        inc_btn = 1'b0;
        ticks(20);
        chk("hold_one_step", 8'(count_w), 8'd1);
        chk("hold_at_min",   8'(at_min_w), 8'd0);

        // Glitches of 1..3 cycles are discarded; 5 cycles counts
        do_reset();
        for (int len = 1; len <= 3; len++) press(1'b1, 1'b0, len, 10);
        chk("glitch", 8'(count_w), 8'd0);
        press(1'b1, 1'b0, 5, 10);
        chk("pulse5", 8'(count_w), 8'd1);

        // Wrap / saturate at the top
        do_load(9);
        wrap_seen_w = 0;
        wrap_seen_s = 0;
        press(1'b1, 1'b0, 8, 10);
        chk("wrap_up_w",  8'(count_w), 8'd0);
        chk("sat_up_s",   8'(count_s), 8'd9);
        chk("wrap_up_nw", 8'(wrap_seen_w), 8'd1);
        chk("sat_up_nw",  8'(wrap_seen_s), 8'd0);
        wrap_seen_w = 0;
        press(1'b0, 1'b1, 8, 10);
        chk("wrap_dn_w",  8'(count_w), 8'd9);
        chk("wrap_dn_nw", 8'(wrap_seen_w), 8'd1);

        do_load(15);
        chk("clamp",     8'(count_w),  8'd9);
        chk("clamp_max", 8'(at_max_w), 8'd1);

        do_load(0);
        wrap_seen_s = 0;
        press(1'b0, 1'b1, 8, 10);
        chk("sat_dn_s",  8'(count_s), 8'd0);
        chk("sat_dn_nw", 8'(wrap_seen_s), 8'd0);

        // Simultaneous presses cancel
        do_load(5);
        press(1'b1, 1'b1, 8, 10);
        chk("both_w", 8'(count_w), 8'd5);
        chk("both_s", 8'(count_s), 8'd5);

        // Load coincident with the step pulse wins and the step is lost
        load_val = 4'd3;
        inc_btn  = 1'b1;
        ticks(6);
        load_en  = 1'b1;
        tick();
        load_en  = 1'b0;
        ticks(5);
        inc_btn  = 1'b0;
        ticks(10);
        chk("load_vs_step", 8'(count_w), 8'd3);

        // Asynchronous reset mid-debounce at count 7
        do_load(7);
        inc_btn = 1'b1;
        ticks(4);
        #1;
        reset_sw = 1'b1;
        model_clear();
        #1;
        chk("async_rst_cnt", 8'(count_w),  8'd0);
        chk("async_rst_min", 8'(at_min_w), 8'd1);
        inc_btn = 1'b0;
        ticks(2);
        reset_sw = 1'b0;
        ticks(20);
        chk("post_rst_nostep", 8'(count_w), 8'd0);

        // Random presses, glitches and loads against the reference model
        for (int it = 0; it < 200; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                do_load(int'($urandom_range(0, 15)));
            end else begin
                press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(1, 10)), int'($urandom_range(0, 8)));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
